// File: rtl/vga_text_pkg.sv
// vga_text_pkg
//   Shared constants and types for the VGA text-mode pipeline: character
//   cell geometry, text-grid dimensions, coordinate widths, the cursor
//   shadow record and a helper that maps a scan coordinate to its cell index.
package vga_text_pkg;

  localparam int CELL_W          = 8;
  localparam int CELL_H          = 8;
  localparam int TEXT_COLS       = 80;
  localparam int TEXT_ROWS       = 60;
  localparam int UNDERLINE_FIRST = 6;

  localparam int SCAN_W = 10;  // pixel column / line width
  localparam int TEXT_W = 8;   // text row / column width

  typedef logic [SCAN_W-1:0] scan_coord_t;
  typedef logic [TEXT_W-1:0] text_coord_t;

  // Cursor registers as frozen at the last frame start.
  typedef struct packed {
    logic        en;
    text_coord_t row;
    text_coord_t col;
  } cursor_shadow_t;

  // Cell index of a scan coordinate. With 8-pixel cells this is the
  // coordinate's upper 7 bits, zero-extended to the text-coordinate width.
  function automatic text_coord_t cell_of(input scan_coord_t p);
    return text_coord_t'(p >> $clog2(CELL_W));
  endfunction

endpackage

// File: rtl/cursor_blink_timer.sv
// cursor_blink_timer
//   Detects frame start (falling edge of the active-low vsync) and runs the
//   cursor blink: blink_on toggles every BLINK_FRAMES frames. When the cursor
//   goes from disabled to enabled at a frame start, the blink restarts in
//   the visible phase with the frame counter cleared.
//
// Ports:
//   clk_i          pixel clock
//   reset_i        synchronous active-high reset
//   vsync_i        vertical sync, active-low
//   c_en_i         live cursor enable (the value about to be shadowed)
//   sh_en_i        currently shadowed cursor enable
//   frame_start_o  one-cycle pulse on the vsync falling edge
//   blink_on_o     1 while the cursor is in the visible blink phase
module cursor_blink_timer
  import vga_text_pkg::*;
#(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic vsync_i,
  input  logic c_en_i,
  input  logic sh_en_i,
  output logic frame_start_o,
  output logic blink_on_o
);

  logic       vsync_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       blink_on_q, blink_on_d;

  // vsync_q resets to 1 so a vsync already low out of reset is not
  // mistaken for a frame start.
  assign frame_start_o = vsync_q & ~vsync_i;
  assign blink_on_o    = blink_on_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start_o) begin
      // A fresh enable restarts the blink so the cursor appears at once;
      // this overrides the regular count.
      if (!sh_en_i && c_en_i) begin
        blink_on_d  = 1'b1;
        frame_cnt_d = '0;
      end else if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_q     <= 1'b1;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      vsync_q     <= vsync_i;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

endmodule

// File: rtl/cursor_overlay.sv
// cursor_overlay
//   XORs a blinking underline (cell lines 6-7) or full-block cursor onto the
//   glyph pixel stream. Cursor enable/row/column are shadowed once per frame
//   so a mid-frame register write never tears the cursor.
//
//   Stream semantics: de_i is a valid-only qualifier; there is no ready and
//   the stream cannot be stalled. Every cycle is consumed. de_o marks the
//   cycles on which pix_o carries an active-video pixel; pix_o/de_o belong to
//   the scan position presented GLYPH_LAT+1 cycles earlier and to the
//   glyph_i presented 1 cycle earlier.
//
// Ports:
//   clk_i, reset_i    pixel clock, synchronous active-high reset
//   c_en_i            cursor enable (live register value)
//   c_row_i, c_col_i  cursor text row / column (live register value)
//   pix_x_i, pix_y_i  current scan position
//   de_i              active-video strobe
//   vsync_i           vertical sync, active-low
//   glyph_i           glyph pixel, GLYPH_LAT cycles behind the scan position
//   pix_o             glyph pixel with cursor applied
//   de_o              de_i aligned with pix_o
module cursor_overlay
  import vga_text_pkg::*;
#(
  parameter int GLYPH_LAT    = 2,
  parameter int BLINK_FRAMES = 16,
  parameter int BLOCK_MODE   = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        c_en_i,
  input  logic [7:0]  c_row_i,
  input  logic [7:0]  c_col_i,
  input  logic [9:0]  pix_x_i,
  input  logic [9:0]  pix_y_i,
  input  logic        de_i,
  input  logic        vsync_i,
  input  logic        glyph_i,
  output logic        pix_o,
  output logic        de_o
);

  cursor_shadow_t sh_q, sh_d;
  logic           frame_start;
  logic           blink_on;
  logic           row_match, col_match, line_ok, hit;

  logic [GLYPH_LAT-1:0] hit_sr_q, hit_sr_d;
  logic [GLYPH_LAT-1:0] de_sr_q, de_sr_d;
  logic                 pix_q, de_q;

  cursor_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .vsync_i       (vsync_i),
    .c_en_i        (c_en_i),
    .sh_en_i       (sh_q.en),
    .frame_start_o (frame_start),
    .blink_on_o    (blink_on)
  );

  // Shadow capture. The hit below reads sh_q, so a frame start landing on
  // an active pixel still uses the previous frame's values for that pixel.
  always_comb begin
    sh_d = sh_q;
    if (frame_start) begin
      sh_d.en  = c_en_i;
      sh_d.row = c_row_i;
      sh_d.col = c_col_i;
    end
  end

  // Out-of-range rows/columns (>=60 / >=80) simply never compare equal
  // inside the visible area, so no clamping is needed.
  always_comb begin
    row_match = (cell_of(pix_y_i) == sh_q.row);
    col_match = (cell_of(pix_x_i) == sh_q.col);
    line_ok   = (BLOCK_MODE != 0) || (pix_y_i[2:0] >= 3'(UNDERLINE_FIRST));
    hit       = de_i & sh_q.en & blink_on & row_match & col_match & line_ok;
  end

  // Delay hit and de to line up with the character generator's glyph_i.
  always_comb begin
    hit_sr_d    = '0;
    de_sr_d     = '0;
    hit_sr_d[0] = hit;
    de_sr_d[0]  = de_i;
    for (int i = 1; i < GLYPH_LAT; i++) begin
      hit_sr_d[i] = hit_sr_q[i-1];
      de_sr_d[i]  = de_sr_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sh_q     <= '0;
      hit_sr_q <= '0;
      de_sr_q  <= '0;
      pix_q    <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      hit_sr_q <= hit_sr_d;
      de_sr_q  <= de_sr_d;
      pix_q    <= glyph_i ^ hit_sr_q[GLYPH_LAT-1];
      de_q     <= de_sr_q[GLYPH_LAT-1];
    end
  end

  assign pix_o = pix_q;
  assign de_o  = de_q;

endmodule

// File: doc/cursor_overlay.md
# cursor_overlay

Downstream consumer of the cursor register block in the VGA text-mode controller. Takes the latched cursor enable/row/column and the scan position from the timing generator, and XORs a blinking underline or block cursor onto the glyph pixel stream from the character generator. Cursor state is shadowed once per frame to prevent tearing. Sits between the character-generator pixel output and the final RGB driver.

## Interface

Parameters:
- GLYPH_LAT, 2: cycles from pix_x_i/pix_y_i/de_i valid to matching glyph_i valid (1..4)
- BLINK_FRAMES, 16: frames per blink half-period (2..255)
- BLOCK_MODE, 0: 0 = underline (cell lines 6–7), 1 = full 8×8 block

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  pixel clock
- reset_i  in  1  synchronous active-high reset
- c_en_i  in  1  cursor enable from cursor regs
- c_row_i  in  8  cursor text row, 0..59
- c_col_i  in  8  cursor text column, 0..79
- pix_x_i  in  10  current pixel column, 0..639 when de_i=1
- pix_y_i  in  10  current pixel line, 0..479 when de_i=1
- de_i  in  1  active-video strobe
- vsync_i  in  1  vertical sync, active-low
- glyph_i  in  1  glyph pixel, GLYPH_LAT cycles behind pix_x_i/pix_y_i/de_i
- pix_o  out  1  glyph pixel with cursor applied
- de_o  out  1  de_i delayed to align with pix_o

## Operation

- Frame start: vsync_i falling edge, detected as vsync_q=1 and vsync_i=0 (vsync_q is vsync_i registered; reset value 1).
- On frame start:
  - Shadow c_en_i, c_row_i, c_col_i into sh_en, sh_row, sh_col.
  - Blink timer: if sh_en is 0 and the new c_en_i is 1, force blink_on=1 and frame_cnt=0. This restart takes priority over the normal count.
  - Otherwise, if frame_cnt==BLINK_FRAMES-1, set frame_cnt=0 and toggle blink_on; else frame_cnt+1.
- Hit (stage 0, combinational on inputs): de_i & sh_en & blink_on & ({1'b0,pix_y_i[9:3]}==sh_row) & ({1'b0,pix_x_i[9:3]}==sh_col) & (BLOCK_MODE | pix_y_i[2:0]>=6).
- Hit and de_i go through a GLYPH_LAT-deep shift register.
- Output register: pix_o <= glyph_i ^ hit_d, de_o <= de_d, where hit_d and de_d are the outputs of that shift register.
- Out-of-range sh_row/sh_col (>59/>79) never match in the visible area, so no cursor is drawn. No clamping is done here.
- Writes to the cursor regs mid-frame have no visible effect until the next frame start.

## Timing

- Latency: pix_o and de_o correspond to the pix_x_i/pix_y_i/de_i presented GLYPH_LAT+1 cycles earlier, and to the glyph_i presented 1 cycle earlier.
- Reset values: pix_o=0, de_o=0, shift register all 0, sh_en=0, sh_row=0, sh_col=0, blink_on=1, frame_cnt=0, vsync_q=1.
- Reset mid-frame: outputs go to 0 on the next edge. No cursor is drawn until the first frame start after reset with c_en_i=1.
- Frame start coinciding with de_i=1 (malformed timing): the shadow update still occurs. That cycle's hit uses the old shadow values.
- Blink period: 2×BLINK_FRAMES frames; visible for the first BLINK_FRAMES frames after enable.

## Structure

- Shared package vga_text_pkg holds:
  - CELL_W=8, CELL_H=8, TEXT_COLS=80, TEXT_ROWS=60, UNDERLINE_FIRST=6
  - scan-coordinate width 10, text-coordinate width 8
- One sub-module: cursor_blink_timer. It contains the vsync edge detect, frame_cnt, blink_on and the enable-restart logic, and outputs frame_start and blink_on.
- The hit comparison, delay line and XOR stay in the top level.

## Test plan

- Reset: hold reset_i 3 cycles with glyph_i=1, de_i=1. Required: pix_o=0 and de_o=0 throughout; after release, pix_o equals glyph_i, since no cursor is shown.
- Underline hit: c_en=1, row=2, col=5, one frame start, GLYPH_LAT=2. Scan pix_x=40..47, pix_y=22..23 with glyph_i=0. Required: pix_o=1 exactly 1 cycle after each matching glyph_i. pix_y=21 gives pix_o=0.
- Block mode: same stimulus with BLOCK_MODE=1 and glyph_i=1 across pix_y=16..23. Required: pix_o=0 (inverted) for all 64 cell pixels and 1 at pix_x=48.
- Blink: BLINK_FRAMES=2, 8 frame starts. Required: cursor visible in frames 0–1, hidden 2–3, visible 4–5, hidden 6–7.
- Tearing and restart:
  - Change col 5→6 mid-frame. Required: column 5 is still drawn in this frame; column 6 from the next frame.
  - Toggle c_en 1→0→1 across frames while hidden. Required: visible immediately at re-enable, with frame_cnt=0.
- Bounds: row=60, col=80 shadowed. Required: pix_o equals glyph_i everywhere.
